eth_regblk: RTL and testbench
=============================

ETH_REGBLK -- requirements
Module: eth_regblk

Interface
REQ-001 Parameter CNT_W, default 11: width of the TX/RX byte-count registers, range 1..16.
REQ-002 Parameter SAN_PULSE, default 2: santm_res_o pulse length in clocks, minimum 1.
REQ-003 Parameter IND_W, default 3: width of the indicator register, range 1..16.
REQ-004 Parameter MD_TMO, default 1024: management-transaction timeout in clocks.
REQ-005 wb_clk_i  in  1  sole clock; all state changes on its rising edge.
REQ-006 wb_rst_i  in  1  reset, asynchronous, active-high.
REQ-007 wb_adr_i  in  3  word register address.
REQ-008 wb_dat_i  in  16  write data.
REQ-009 wb_dat_o  out  16  registered read data.
REQ-010 wb_cyc_i  in  1  bus cycle.
REQ-011 wb_stb_i  in  1  strobe.
REQ-012 wb_we_i  in  1  1 = write, 0 = read.
REQ-013 wb_sel_i  in  2  byte lanes; [0] = bits 7:0, [1] = bits 15:8.
REQ-014 wb_ack_o  out  1  acknowledge.
REQ-015 e_mode_o  out  8  mode register; bit7 = rxdone, bit6 = txrdy.
REQ-016 e_sts_i  in  8  MAC status; bit7 = rxrdy; bits 5:0 = error flags.
REQ-017 e_txcnt_o  out  CNT_W  TX byte count.
REQ-018 e_rxcnt_i  in  CNT_W  RX byte count.
REQ-019 md_wdata_o  out  16  management write data.
REQ-020 md_rdata_i  in  16  management read data, valid with md_done_i.
REQ-021 md_ctrl_o  out  6  {wr, addr[4:0]}; held stable while busy.
REQ-022 md_start_o  out  1  one-clock transaction start pulse.
REQ-023 md_done_i  in  1  one-clock transaction completion.
REQ-024 md_status_i  in  8  PHY link/speed status.
REQ-025 santm_res_o  out  1  sanity-timer reset pulse.
REQ-026 dev_ind_o  out  IND_W  indicator outputs.
REQ-027 irq_o  out  1  level interrupt.

Function
REQ-028 Access and acknowledge:
- An access starts only when wb_cyc_i & wb_stb_i & ~wb_ack_o.
- wb_ack_o asserts the clock after the access starts and drops the following clock, so each access acks exactly once.
- wb_dat_o loads on the same edge as wb_ack_o rises.
REQ-029 Register map, by word address:
- 0: read {e_mode, e_sts_i}; writing lane 0 loads the mode register.
- 1: read {zero-pad, e_rxcnt_i}; a write loads txcnt per lane, and bits at or above CNT_W are ignored.
- 2: a write loads md_wdata per lane; a read returns md_rdata_latch.
- 3: writing lane 0 loads md_ctrl from bits 6:0 (bit6 = wr, bit5 = start, bits 4:0 = addr); a read returns {busy, 7'b0, md_status_i}.
- 4: read {8'b0, err}; writing lane 0 is write-one-to-clear.
- 5: irq_en[7:0] (see REQ-041).
- 6: writing lane 0 with bit0 = 1 triggers the sanity pulse.
- 7: dev_ind, IND_W bits, written per lane; a read returns the zero-padded value.
- Unmapped read bits return 0.
REQ-030 Mode auto-clear: on any clock without a write to address 0, if e_mode[7] = 1 and e_sts_i[7] = 0, e_mode[7] shall clear.
REQ-031 Sticky errors:
- err[5:0] sets on any clock where e_sts_i[5:0] bit = 1.
- err[6] = management timeout; err[7] = management overrun.
- If set and write-one-to-clear hit the same bit in one clock, set wins.
REQ-032 Management FSM, states IDLE, START, WAIT:
- IDLE -> START on a write to address 3 with bit5 = 1.
- START drives md_start_o = 1 for exactly one clock, then -> WAIT.
- WAIT -> IDLE on md_done_i; if wr = 0, md_rdata_i is latched into md_rdata_latch.
- busy = (state != IDLE).
REQ-033 Management timeout: a counter clears on entry to WAIT; if it reaches MD_TMO-1 without md_done_i, the FSM returns to IDLE, sets err[6] and leaves md_rdata_latch unchanged.
REQ-034 Writes while busy: a write to address 3 while busy is ignored entirely and sets err[7]; writes to address 2 while busy are also ignored.
REQ-035 Stray completion: md_done_i in IDLE or START is ignored.
REQ-036 Sanity pulse: santm_res_o is driven high for exactly SAN_PULSE clocks after the trigger write; a retrigger during a pulse restarts the full count.

Reset
REQ-037 While wb_rst_i = 1, every register and output shall be 0 and the FSM shall be in IDLE; this includes wb_ack_o, wb_dat_o, e_mode, txcnt, md_wdata, md_ctrl, md_rdata_latch, err, irq_en, dev_ind and the pulse counter.
REQ-038 Reset asserted mid-transaction shall abort it with no md_start_o and no err update; after release, the first access shall ack normally.

Configuration
REQ-039 Macro ETHCTL_IRQ_EN selects whether the interrupt logic is compiled in.
REQ-040 Without ETHCTL_IRQ_EN: irq_o is tied to 0, address 5 reads 0 and writes to it are ignored.
REQ-041 With ETHCTL_IRQ_EN: address 5 holds irq_en[7:0] (read/write), and irq_o = |(err & irq_en) is registered (one-clock latency).

Verification
REQ-042 Write 0x0080 to address 0 while e_sts_i = 0x80, then drive e_sts_i = 0x00 -> e_mode_o[7] clears the next clock and a read of address 0 returns 0x0000.
REQ-043 Write 0x0025 to address 3, pulse md_done_i 5 clocks later with md_rdata_i = 0xBEEF -> one md_start_o pulse, busy reads 1, then address 2 reads 0xBEEF.
REQ-044 Start a transaction with MD_TMO = 16 and no md_done_i -> returns to IDLE after 16 WAIT clocks and address 4 reads 0x0040; writing 0x0040 to address 4 then reads 0x0000.
REQ-045 Write address 3 while busy -> md_ctrl_o unchanged, no second md_start_o, and err[7] = 1.
REQ-046 Hold e_sts_i[0] = 1 while writing 0x0001 to address 4 -> err[0] stays 1.
REQ-047 With ETHCTL_IRQ_EN: set irq_en = 0x01 and raise e_sts_i[0] -> irq_o = 1 two clocks later; also write address 6 twice, 1 clock apart, with SAN_PULSE = 2 -> santm_res_o stays high for 3 clocks.

Source files
------------

// File: rtl/eth_regblk.sv
// Ethernet MAC control register block on a 16-bit Wishbone slave port.
// Holds the mode, TX count, management (MDIO-style) transaction engine,
// sticky error flags, sanity-timer pulse and indicator registers.
// Optional interrupt logic is compiled in when ETHCTL_IRQ_EN is defined.

module eth_regblk #(
    parameter int unsigned CNT_W     = 11,
    parameter int unsigned SAN_PULSE = 2,
    parameter int unsigned IND_W     = 3,
    parameter int unsigned MD_TMO    = 1024
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic [2:0]        wb_adr_i,
    input  logic [15:0]       wb_dat_i,
    output logic [15:0]       wb_dat_o,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic              wb_we_i,
    input  logic [1:0]        wb_sel_i,
    output logic              wb_ack_o,
    output logic [7:0]        e_mode_o,
    input  logic [7:0]        e_sts_i,
    output logic [CNT_W-1:0]  e_txcnt_o,
    input  logic [CNT_W-1:0]  e_rxcnt_i,
    output logic [15:0]       md_wdata_o,
    input  logic [15:0]       md_rdata_i,
    output logic [5:0]        md_ctrl_o,
    output logic              md_start_o,
    input  logic              md_done_i,
    input  logic [7:0]        md_status_i,
    output logic              santm_res_o,
    output logic [IND_W-1:0]  dev_ind_o,
    output logic              irq_o
);

    localparam int unsigned TMO_W = (MD_TMO > 1) ? $clog2(MD_TMO) : 1;
    localparam int unsigned SAN_W = $clog2(SAN_PULSE + 1);

    typedef enum logic [1:0] {StIdle, StStart, StWait} md_state_e;

    logic              ack_q, ack_d;
    logic [15:0]       dat_q, dat_d;
    logic [7:0]        mode_q, mode_d;
    logic [CNT_W-1:0]  txcnt_q, txcnt_d;
    logic [15:0]       md_wdata_q, md_wdata_d;
    logic [5:0]        md_ctrl_q, md_ctrl_d;
    logic [15:0]       md_latch_q, md_latch_d;
    logic [7:0]        err_q, err_d;
    logic [IND_W-1:0]  dev_ind_q, dev_ind_d;
    logic [SAN_W-1:0]  san_q, san_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    md_state_e         state_q, state_d;
    logic              md_start_q, md_start_d;
    logic [7:0]        irq_en_q;
    logic              irq_q;

    logic              access;
    logic              wr_acc;
    logic              busy;
    logic              tmo_err;
    logic              ovr_err;
    logic [7:0]        w1c;
    logic [15:0]       rdata;

    assign access = wb_cyc_i & wb_stb_i & ~ack_q;
    assign wr_acc = access & wb_we_i;
    assign busy   = (state_q != StIdle);

    function automatic logic [15:0] lane_merge(input logic [15:0] cur, input logic [15:0] dat,
                                               input logic [1:0] sel);
        lane_merge = cur;
        if (sel[0]) lane_merge[7:0]  = dat[7:0];
        if (sel[1]) lane_merge[15:8] = dat[15:8];
    endfunction

    function automatic logic wr_to(input logic [2:0] addr);
        wr_to = wr_acc && (wb_adr_i == addr);
    endfunction

    // Read-data mux, sampled into wb_dat_o on the edge that raises ack.
    always_comb begin
        rdata = '0;
        case (wb_adr_i)
            3'd0: rdata = {mode_q, e_sts_i};
            3'd1: rdata = 16'(e_rxcnt_i);
            3'd2: rdata = md_latch_q;
            3'd3: rdata = {busy, 7'b0, md_status_i};
            3'd4: rdata = {8'b0, err_q};
            3'd5: rdata = {8'b0, irq_en_q};
            3'd6: rdata = '0;
            3'd7: rdata = 16'(dev_ind_q);
            default: rdata = '0;
        endcase
    end

    // Bus handshake plus plain data registers (mode, txcnt, wdata, indicators).
    always_comb begin
        ack_d = access;
        dat_d = access ? rdata : dat_q;

        mode_d = mode_q;
        if (wr_to(3'd0)) begin
            if (wb_sel_i[0]) mode_d = wb_dat_i[7:0];
        end else if (mode_q[7] && !e_sts_i[7]) begin
            // rxdone self-clears once the MAC drops rxrdy
            mode_d[7] = 1'b0;
        end

        txcnt_d = wr_to(3'd1) ? CNT_W'(lane_merge(16'(txcnt_q), wb_dat_i, wb_sel_i)) : txcnt_q;
        md_wdata_d = (wr_to(3'd2) && !busy) ? lane_merge(md_wdata_q, wb_dat_i, wb_sel_i)
                                            : md_wdata_q;
        dev_ind_d = wr_to(3'd7) ? IND_W'(lane_merge(16'(dev_ind_q), wb_dat_i, wb_sel_i))
                                : dev_ind_q;
    end

    // Management transaction engine: IDLE -> START (one-clock pulse) -> WAIT.
    always_comb begin
        state_d    = state_q;
        tmo_d      = tmo_q;
        md_ctrl_d  = md_ctrl_q;
        md_latch_d = md_latch_q;
        tmo_err    = 1'b0;
        ovr_err    = 1'b0;

        if (wr_to(3'd3)) begin
            if (busy) begin
                ovr_err = 1'b1;
            end else if (wb_sel_i[0]) begin
                md_ctrl_d = {wb_dat_i[6], wb_dat_i[4:0]};
                if (wb_dat_i[5]) state_d = StStart;
            end
        end

        case (state_q)
            StIdle: ;
            StStart: begin
                state_d = StWait;
                tmo_d   = '0;
            end
            StWait: begin
                if (md_done_i) begin
                    state_d = StIdle;
                    if (!md_ctrl_q[5]) md_latch_d = md_rdata_i;
                end else if (tmo_q == TMO_W'(MD_TMO - 1)) begin
                    state_d = StIdle;
                    tmo_err = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        md_start_d = (state_d == StStart);
    end

    // Sticky errors (set beats clear) and the retriggerable sanity pulse counter.
    always_comb begin
        w1c   = (wr_to(3'd4) && wb_sel_i[0]) ? wb_dat_i[7:0] : 8'h00;
        err_d = (err_q & ~w1c) | {ovr_err, tmo_err, e_sts_i[5:0]};

        san_d = san_q;
        if (wr_to(3'd6) && wb_sel_i[0] && wb_dat_i[0]) begin
            san_d = SAN_W'(SAN_PULSE);
        end else if (san_q != '0) begin
            san_d = san_q - 1'b1;
        end
    end

    // State registers.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack_q      <= 1'b0;
            dat_q      <= '0;
            mode_q     <= '0;
            txcnt_q    <= '0;
            md_wdata_q <= '0;
            md_ctrl_q  <= '0;
            md_latch_q <= '0;
            err_q      <= '0;
            dev_ind_q  <= '0;
            san_q      <= '0;
            tmo_q      <= '0;
            state_q    <= StIdle;
            md_start_q <= 1'b0;
        end else begin
            ack_q      <= ack_d;
            dat_q      <= dat_d;
            mode_q     <= mode_d;
            txcnt_q    <= txcnt_d;
            md_wdata_q <= md_wdata_d;
            md_ctrl_q  <= md_ctrl_d;
            md_latch_q <= md_latch_d;
            err_q      <= err_d;
            dev_ind_q  <= dev_ind_d;
            san_q      <= san_d;
            tmo_q      <= tmo_d;
            state_q    <= state_d;
            md_start_q <= md_start_d;
        end
    end

`ifdef ETHCTL_IRQ_EN
    logic [7:0] irq_en_d;
    logic       irq_d;

    // Interrupt enable register and registered level interrupt.
    always_comb begin
        irq_en_d = (wr_to(3'd5) && wb_sel_i[0]) ? wb_dat_i[7:0] : irq_en_q;
        irq_d    = |(err_q & irq_en_q);
    end

    // Interrupt registers.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            irq_en_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
        end
    end
`else
    assign irq_en_q = 8'h00;
    assign irq_q    = 1'b0;
`endif

    assign wb_ack_o    = ack_q;
    assign wb_dat_o    = dat_q;
    assign e_mode_o    = mode_q;
    assign e_txcnt_o   = txcnt_q;
    assign md_wdata_o  = md_wdata_q;
    assign md_ctrl_o   = md_ctrl_q;
    assign md_start_o  = md_start_q;
    assign santm_res_o = (san_q != '0);
    assign dev_ind_o   = dev_ind_q;
    assign irq_o       = irq_q;

endmodule

// File: tb/tb_eth_regblk.sv
// Directed testbench for eth_regblk (MD_TMO shortened to 16).

module tb_eth_regblk;

    localparam int unsigned CNT_W     = 11;
    localparam int unsigned SAN_PULSE = 2;
    localparam int unsigned IND_W     = 3;
    localparam int unsigned MD_TMO    = 16;

    logic              clk;
    logic              rst;
    logic [2:0]        adr;
    logic [15:0]       dat_w;
    logic [15:0]       dat_r;
    logic              cyc, stb, we;
    logic [1:0]        sel;
    logic              ack;
    logic [7:0]        e_mode;
    logic [7:0]        e_sts;
    logic [CNT_W-1:0]  txcnt;
    logic [CNT_W-1:0]  rxcnt;
    logic [15:0]       md_wdata;
    logic [15:0]       md_rdata;
    logic [5:0]        md_ctrl;
    logic              md_start;
    logic              md_done;
    logic [7:0]        md_status;
    logic              santm;
    logic [IND_W-1:0]  dev_ind;
    logic              irq;

    int n_checks = 0;
    int n_errors = 0;
    int start_cnt = 0;
    int san_cnt = 0;
    int s0;
    logic [15:0] rv;

    eth_regblk #(
        .CNT_W    (CNT_W),
        .SAN_PULSE(SAN_PULSE),
        .IND_W    (IND_W),
        .MD_TMO   (MD_TMO)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .wb_adr_i   (adr),
        .wb_dat_i   (dat_w),
        .wb_dat_o   (dat_r),
        .wb_cyc_i   (cyc),
        .wb_stb_i   (stb),
        .wb_we_i    (we),
        .wb_sel_i   (sel),
        .wb_ack_o   (ack),
        .e_mode_o   (e_mode),
        .e_sts_i    (e_sts),
        .e_txcnt_o  (txcnt),
        .e_rxcnt_i  (rxcnt),
        .md_wdata_o (md_wdata),
        .md_rdata_i (md_rdata),
        .md_ctrl_o  (md_ctrl),
        .md_start_o (md_start),
        .md_done_i  (md_done),
        .md_status_i(md_status),
        .santm_res_o(santm),
        .dev_ind_o  (dev_ind),
        .irq_o      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse monitors, sampled mid-cycle.
    always @(negedge clk) begin
        if (md_start) start_cnt++;
        if (santm) san_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called on a negedge; returns on a negedge with the bus idle and ack dropped.
    task automatic bus_xfer(input logic w, input logic [2:0] a, input logic [15:0] d,
                            input logic [1:0] s, output logic [15:0] r);
        int waited;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d; sel = s;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!ack && waited < 4);
        check_eq("ack", {31'b0, ack}, 32'd1);
        r = dat_r;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        logic [15:0] r;
        bus_xfer(1'b1, a, d, 2'b11, r);
    endtask

    task automatic wr_lane(input logic [2:0] a, input logic [15:0] d, input logic [1:0] s);
        logic [15:0] r;
        bus_xfer(1'b1, a, d, s, r);
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] a, input logic [15:0] exp);
        logic [15:0] r;
        bus_xfer(1'b0, a, 16'h0000, 2'b11, r);
        check_eq(tag, {16'b0, r}, {16'b0, exp});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; adr = '0; dat_w = '0; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0;
        e_sts = '0; rxcnt = '0; md_rdata = '0; md_done = 1'b0; md_status = 8'h5A;
        repeat (3) @(negedge clk);

        // Reset state
        check_eq("rst_ack_dat", {15'b0, ack, dat_r}, 32'd0);
        check_eq("rst_mode_tx", {13'b0, e_mode, txcnt}, 32'd0);
        check_eq("rst_md", {md_wdata, 8'b0, md_ctrl, md_start, santm}, 32'd0);
        check_eq("rst_ind_irq", {28'b0, dev_ind, irq}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Mode register and rxdone auto-clear
        e_sts = 8'h80;
        wr(3'd0, 16'h0080);
        check_eq("mode_set", {24'b0, e_mode}, 32'h80);
        e_sts = 8'h00;
        @(negedge clk);
        check_eq("mode_autoclr", {24'b0, e_mode}, 32'h00);
        rd_chk("rd_addr0_clr", 3'd0, 16'h0000);
        e_sts = 8'h12;
        wr(3'd0, 16'h0040);
        rd_chk("rd_addr0_txrdy", 3'd0, 16'h4012);
        e_sts = 8'h00;
        wr(3'd4, 16'h00FF);  // clear the flags from e_sts = 0x12

        // TX/RX counts, lanes and truncation
        wr(3'd1, 16'hFFFF);
        check_eq("txcnt_trunc", {21'b0, txcnt}, 32'h7FF);
        wr_lane(3'd1, 16'h1234, 2'b01);
        check_eq("txcnt_lane0", {21'b0, txcnt}, 32'h734);
        rxcnt = 11'h5A5;
        rd_chk("rd_rxcnt", 3'd1, 16'h05A5);

        // Indicators, address 6 reads zero
        wr_lane(3'd7, 16'h00FF, 2'b01);
        check_eq("dev_ind", {29'b0, dev_ind}, 32'h7);
        rd_chk("rd_dev_ind", 3'd7, 16'h0007);
        rd_chk("rd_addr6", 3'd6, 16'h0000);

        // Management read transaction
        wr(3'd2, 16'hA55A);
        check_eq("md_wdata", {16'b0, md_wdata}, 32'hA55A);
        s0 = start_cnt;
        wr(3'd3, 16'h0025);
        check_eq("md_ctrl", {26'b0, md_ctrl}, 32'h05);
        rd_chk("busy_rd", 3'd3, 16'h805A);
        @(negedge clk);
        md_done = 1'b1; md_rdata = 16'hBEEF;
        @(negedge clk);
        md_done = 1'b0; md_rdata = 16'h0000;
        check_eq("start_once", s0 + 1, start_cnt);
        rd_chk("rdata_latch", 3'd2, 16'hBEEF);
        rd_chk("idle_rd", 3'd3, 16'h005A);

        // Management write transaction: no latch, wdata locked while busy
        wr(3'd3, 16'h0067);
        wr(3'd2, 16'h1234);
        check_eq("wdata_locked", {16'b0, md_wdata}, 32'hA55A);
        md_done = 1'b1; md_rdata = 16'h1111;
        @(negedge clk);
        md_done = 1'b0; md_rdata = 16'h0000;
        rd_chk("wr_no_latch", 3'd2, 16'hBEEF);
        rd_chk("err_clean", 3'd4, 16'h0000);

        // Timeout: WAIT entered at edge 2; returns to IDLE at edge 18
        wr(3'd3, 16'h0025);
        repeat (14) @(negedge clk);
        rd_chk("tmo_still_busy", 3'd3, 16'h805A);
        rd_chk("tmo_idle", 3'd3, 16'h005A);
        rd_chk("tmo_err", 3'd4, 16'h0040);
        wr(3'd4, 16'h0040);
        rd_chk("tmo_err_clr", 3'd4, 16'h0000);

        // Overrun: write to address 3 while busy
        s0 = start_cnt;
        wr(3'd3, 16'h0025);
        wr(3'd3, 16'h0063);
        check_eq("ovr_ctrl_kept", {26'b0, md_ctrl}, 32'h05);
        repeat (20) @(negedge clk);
        check_eq("ovr_one_start", s0 + 1, start_cnt);
        rd_chk("ovr_err", 3'd4, 16'h00C0);
        wr(3'd4, 16'h00C0);
        rd_chk("ovr_err_clr", 3'd4, 16'h0000);

        // Set wins over write-one-to-clear
        e_sts = 8'h01;
        wr(3'd4, 16'h0001);
        rd_chk("set_wins", 3'd4, 16'h0001);
        e_sts = 8'h00;
        wr(3'd4, 16'h0001);
        rd_chk("w1c", 3'd4, 16'h0000);

        // Sanity pulse: single trigger, then back-to-back retrigger (2 edges apart)
        s0 = san_cnt;
        wr(3'd6, 16'h0001);
        repeat (6) @(negedge clk);
        check_eq("san_single", san_cnt - s0, 32'd2);
        s0 = san_cnt;
        wr(3'd6, 16'h0001);
        wr(3'd6, 16'h0001);
        repeat (6) @(negedge clk);
        check_eq("san_retrig", san_cnt - s0, 32'd4);
        s0 = san_cnt;
        wr(3'd6, 16'h0000);
        repeat (4) @(negedge clk);
        check_eq("san_bit0_clear", san_cnt - s0, 32'd0);

`ifdef ETHCTL_IRQ_EN
        wr(3'd5, 16'h0001);
        rd_chk("irq_en_rd", 3'd5, 16'h0001);
        e_sts = 8'h01;
        @(negedge clk);
        check_eq("irq_lat1", {31'b0, irq}, 32'd0);
        e_sts = 8'h00;
        @(negedge clk);
        check_eq("irq_lat2", {31'b0, irq}, 32'd1);
        wr(3'd4, 16'h0001);
        check_eq("irq_clr", {31'b0, irq}, 32'd0);
`else
        wr(3'd5, 16'hFFFF);
        rd_chk("irq_en_absent", 3'd5, 16'h0000);
        e_sts = 8'h01;
        repeat (3) @(negedge clk);
        check_eq("irq_tied", {31'b0, irq}, 32'd0);
        e_sts = 8'h00;
        wr(3'd4, 16'h00FF);
`endif

        // Reset mid-transaction
        s0 = start_cnt;
        wr(3'd3, 16'h0025);
        rst = 1'b1;
        #1;
        check_eq("midrst_ctrl", {26'b0, md_ctrl}, 32'd0);
        check_eq("midrst_regs", {5'b0, e_mode, txcnt, md_start, dev_ind, santm, irq}, 32'd0);
        check_eq("midrst_wdata", {16'b0, md_wdata}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("midrst_starts", s0 + 1, start_cnt);
        rd_chk("midrst_idle", 3'd3, 16'h005A);
        rd_chk("midrst_noerr", 3'd4, 16'h0000);
        rd_chk("midrst_latch", 3'd2, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
